// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache controller among NUM_REQ requesters.
// Optional watchdog abort enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int KEY_WIDTH      = 16,
  parameter int VALUE_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*2-1:0]           req_op_i,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key_i,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_val_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic                           rsp_hit_o,
  output logic                           rsp_err_o,
  output logic [VALUE_WIDTH-1:0]         rsp_data_o,
  output logic                           ctrl_valid_o,
  input  logic                           ctrl_ready_i,
  output logic [1:0]                     ctrl_op_o,
  output logic [KEY_WIDTH-1:0]           ctrl_key_o,
  output logic [VALUE_WIDTH-1:0]         ctrl_val_o,
  input  logic                           ctrl_done_i,
  input  logic                           ctrl_hit_i,
  input  logic [VALUE_WIDTH-1:0]         ctrl_data_i,
  output logic                           ctrl_abort_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gnt_q, gnt_d;
  logic [1:0]             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] val_q, val_d;
  logic                   hit_q, hit_d;
  logic                   err_q, err_d;
  logic [VALUE_WIDTH-1:0] data_q, data_d;

  logic [IW-1:0] sel;
  logic [IW-1:0] sel_nxt;
  logic          sel_vld;
  logic          done_ok;
  logic          tmo;
  logic [1:0]    sel_op;

  // first valid requester at or after the pointer, wrapping
  always_comb begin
    int j;
    j       = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!sel_vld && req_valid_i[j]) begin
        sel_vld = 1'b1;
        sel     = IW'(j);
      end
    end
  end

  assign sel_nxt = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign sel_op  = req_op_i[int'(sel)*2 +: 2];

  // completion counts in WAIT, or in ISSUE when accepted the same cycle
  assign done_ok = ctrl_done_i &&
                   ((state_q == S_WAIT) ||
                    ((state_q == S_ISSUE) && ctrl_ready_i));

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy;

  assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign tmo  = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  assign ctrl_abort_o = tmo && !done_ok;

  // watchdog counts only while a command is outstanding
  always_comb begin
    cnt_d = '0;
    if (busy) cnt_d = cnt_q + 1'b1;
  end

  // watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
  // tied low; the limit only matters with the watchdog built in
  assign ctrl_abort_o = (TIMEOUT_CYCLES < 0);
`endif

  // next-state, latching and handshake outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    key_d       = key_q;
    val_d       = val_q;
    hit_d       = hit_q;
    err_d       = err_q;
    data_d      = data_q;
    req_ready_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          req_ready_o[sel] = 1'b1;
          gnt_d = sel;
          ptr_d = sel_nxt;
          op_d  = sel_op;
          key_d = req_key_i[int'(sel)*KEY_WIDTH +: KEY_WIDTH];
          val_d = req_val_i[int'(sel)*VALUE_WIDTH +: VALUE_WIDTH];
          hit_d  = 1'b0;
          data_d = '0;
          if (sel_op == 2'b00) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        if (done_ok) begin
          hit_d   = ctrl_hit_i;
          data_d  = ctrl_data_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo) begin
          hit_d   = 1'b0;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (state_q == S_ISSUE && ctrl_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // response strobe to the granted requester, zero otherwise
  always_comb begin
    rsp_valid_o = '0;
    if (state_q == S_RESP) rsp_valid_o[gnt_q] = 1'b1;
  end

  assign rsp_hit_o    = (state_q == S_RESP) && hit_q;
  assign rsp_err_o    = (state_q == S_RESP) && err_q;
  assign rsp_data_o   = (state_q == S_RESP) ? data_q : '0;
  assign ctrl_valid_o = (state_q == S_ISSUE);
  assign ctrl_op_o    = op_q;
  assign ctrl_key_o   = key_q;
  assign ctrl_val_o   = val_q;

  // state, pointer and payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      key_q   <= '0;
      val_q   <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      key_q   <= key_d;
      val_q   <= val_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

endmodule
